// File: rtl/bnn_pkg.sv
// Shared definitions for the binary-neural-net popcount blocks: width helper,
// accumulator FSM encodings and the default activation threshold.
package bnn_pkg;

    localparam int unsigned DEFAULT_THRESH = 32'd0;

    typedef enum logic [0:0] {
        ST_FIRST = 1'b0,
        ST_ACC   = 1'b1
    } acc_state_e;

    // Ceiling log2; clog2(n + 1) is the width needed to hold a count of 0..n.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned rem;
        res = 32'd0;
        rem = value - 32'd1;
        while (rem > 32'd0) begin
            res = res + 32'd1;
            rem = rem >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/popcount_tree.sv
// Combinational balanced adder tree counting the set bits of vec_i.
// Each node recurses on two halves, sized to the narrowest width that fits.
module popcount_tree
    import bnn_pkg::*;
#(
    parameter int unsigned VWIDTH = 64,
    parameter int unsigned CWIDTH = 16
) (
    input  logic [VWIDTH-1:0] vec_i,
    output logic [CWIDTH-1:0] cnt_o
);

    generate
        if (VWIDTH == 1) begin : g_leaf
            assign cnt_o = CWIDTH'(vec_i);
        end else begin : g_node
            localparam int unsigned LO_W  = VWIDTH / 32'd2;
            localparam int unsigned HI_W  = VWIDTH - LO_W;
            localparam int unsigned LO_CW = clog2(LO_W + 32'd1);
            localparam int unsigned HI_CW = clog2(HI_W + 32'd1);

            logic [LO_CW-1:0] lo_cnt_s;
            logic [HI_CW-1:0] hi_cnt_s;

            popcount_tree #(
                .VWIDTH(LO_W),
                .CWIDTH(LO_CW)
            ) u_lo (
                .vec_i(vec_i[LO_W-1:0]),
                .cnt_o(lo_cnt_s)
            );

            popcount_tree #(
                .VWIDTH(HI_W),
                .CWIDTH(HI_CW)
            ) u_hi (
                .vec_i(vec_i[VWIDTH-1:LO_W]),
                .cnt_o(hi_cnt_s)
            );

            assign cnt_o = CWIDTH'(lo_cnt_s) + CWIDTH'(hi_cnt_s);
        end
    endgenerate

endmodule

// File: rtl/popcount_acc.sv
// Two-stage popcount accumulator: S1 registers the beat count, S2 accumulates
// (saturating) per vector. Define POPCOUNT_ACC_XNOR_EN to count ~(ivec ^ wvec).
module popcount_acc
    import bnn_pkg::*;
#(
    parameter int unsigned       VWIDTH = 64,
    parameter int unsigned       CWIDTH = 16,
    parameter logic [CWIDTH-1:0] THRESH = CWIDTH'(DEFAULT_THRESH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [VWIDTH-1:0] ivec,
`ifdef POPCOUNT_ACC_XNOR_EN
    input  logic [VWIDTH-1:0] wvec,
`endif
    input  logic              ivalid,
    input  logic              ilast,
    output logic              iready,
    output logic [CWIDTH-1:0] osum,
    output logic              oact,
    output logic              osat,
    output logic              ovalid,
    input  logic              oready
);

    localparam logic [CWIDTH-1:0] SAT_MAX = {CWIDTH{1'b1}};

    logic              en_s;
    logic              beat_s2_s;
    logic              load_s;
    logic [VWIDTH-1:0] cnt_vec_s;
    logic [CWIDTH-1:0] beat_cnt_s;
    logic [CWIDTH:0]   sum_s;

    logic              s1_valid_q, s1_valid_d;
    logic              s1_last_q,  s1_last_d;
    logic [CWIDTH-1:0] s1_cnt_q,   s1_cnt_d;
    logic [CWIDTH-1:0] acc_q,      acc_d;
    logic              sat_q,      sat_d;
    logic [CWIDTH-1:0] osum_q,     osum_d;
    logic              oact_q,     oact_d;
    logic              osat_q,     osat_d;
    logic              ovalid_q,   ovalid_d;
    acc_state_e        state_q,    state_d;

`ifdef POPCOUNT_ACC_XNOR_EN
    assign cnt_vec_s = ~(ivec ^ wvec);
`else
    assign cnt_vec_s = ivec;
`endif

    popcount_tree #(
        .VWIDTH(VWIDTH),
        .CWIDTH(CWIDTH)
    ) u_tree (
        .vec_i(cnt_vec_s),
        .cnt_o(beat_cnt_s)
    );

    // A pending result that is not taken freezes the whole pipe.
    assign en_s      = !ovalid_q || oready;
    assign beat_s2_s = en_s && s1_valid_q;
    assign iready    = rst_n && en_s;

    // Stage 1 next state: capture the beat count when the pipe advances.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_last_d  = s1_last_q;
        s1_cnt_d   = s1_cnt_q;
        if (en_s) begin
            s1_valid_d = ivalid;
            s1_last_d  = ilast;
            s1_cnt_d   = beat_cnt_s;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // FSM next state: a last beat always returns to FIRST.
    always_comb begin
        state_d = state_q;
        if (beat_s2_s) begin
            case (state_q)
                ST_FIRST: state_d = s1_last_q ? ST_FIRST : ST_ACC;
                ST_ACC:   state_d = s1_last_q ? ST_FIRST : ST_ACC;
                default:  state_d = ST_FIRST;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FSM output decode: load the accumulator on the first beat of a vector.
    always_comb begin
        load_s = 1'b1;
        case (state_q)
            ST_FIRST: load_s = 1'b1;
            ST_ACC:   load_s = 1'b0;
            default:  load_s = 1'b1;
        endcase
    end

    // Stage 2: saturating accumulate and result capture.
    always_comb begin
        sum_s    = {1'b0, acc_q} + {1'b0, s1_cnt_q};
        acc_d    = acc_q;
        sat_d    = sat_q;
        osum_d   = osum_q;
        oact_d   = oact_q;
        osat_d   = osat_q;
        ovalid_d = ovalid_q;
        if (beat_s2_s) begin
            if (load_s) begin
                acc_d = s1_cnt_q;
                sat_d = 1'b0;
            end else if (sum_s[CWIDTH]) begin
                acc_d = SAT_MAX;
                sat_d = 1'b1;
            end else begin
                acc_d = sum_s[CWIDTH-1:0];
                sat_d = sat_q;
            end
            if (s1_last_q) begin
                osum_d = acc_d;
                oact_d = (acc_d >= THRESH);
                osat_d = sat_d;
            end else if (load_s) begin
                osat_d = 1'b0;
            end else begin
                osat_d = osat_q;
            end
        end else begin
            acc_d = acc_q;
        end
        if (en_s) begin
            ovalid_d = s1_valid_q && s1_last_q;
        end else begin
            ovalid_d = ovalid_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_cnt_q   <= {CWIDTH{1'b0}};
            acc_q      <= {CWIDTH{1'b0}};
            sat_q      <= 1'b0;
            osum_q     <= {CWIDTH{1'b0}};
            oact_q     <= 1'b0;
            osat_q     <= 1'b0;
            ovalid_q   <= 1'b0;
            state_q    <= ST_FIRST;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s1_cnt_q   <= s1_cnt_d;
            acc_q      <= acc_d;
            sat_q      <= sat_d;
            osum_q     <= osum_d;
            oact_q     <= oact_d;
            osat_q     <= osat_d;
            ovalid_q   <= ovalid_d;
            state_q    <= state_d;
        end
    end

    assign osum   = osum_q;
    assign oact   = oact_q;
    assign osat   = osat_q;
    assign ovalid = ovalid_q;

endmodule

// File: tb/tb_popcount_acc.sv
// Scoreboard bench for popcount_acc (VWIDTH=8, CWIDTH=8, THRESH=12); covers the
// XNOR datapath too when POPCOUNT_ACC_XNOR_EN is defined.
`timescale 1ns/1ps
module tb_popcount_acc;

    localparam logic [7:0] TH = 8'd12;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ivec;
    logic [7:0] wvec;
    logic       ivalid;
    logic       ilast;
    logic       iready;
    logic [7:0] osum;
    logic       oact;
    logic       osat;
    logic       ovalid;
    logic       oready;

    typedef struct packed {
        logic [7:0] sum;
        logic       act;
        logic       sat;
    } res_t;

    res_t       sb_q[$];
    res_t       mon_exp;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] m_acc;
    logic       m_sat;
    logic       m_first;
    bit         rnd_ready_en = 1'b0;

    popcount_acc #(
        .VWIDTH(8),
        .CWIDTH(8),
        .THRESH(TH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ivec  (ivec),
`ifdef POPCOUNT_ACC_XNOR_EN
        .wvec  (wvec),
`endif
        .ivalid(ivalid),
        .ilast (ilast),
        .iready(iready),
        .osum  (osum),
        .oact  (oact),
        .osat  (osat),
        .ovalid(ovalid),
        .oready(oready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int beat_count(input logic [7:0] v);
`ifdef POPCOUNT_ACC_XNOR_EN
        return $countones(~(v ^ wvec));
`else
        return $countones(v);
`endif
    endfunction

    // Reference model of one accepted beat.
    task automatic model_accept(input logic [7:0] v, input logic last);
        int cnt;
        int s;
        cnt = beat_count(v);
        if (m_first) begin
            m_acc = cnt[7:0];
            m_sat = 1'b0;
        end else begin
            s = int'(m_acc) + cnt;
            if (s > 255) begin
                m_acc = 8'd255;
                m_sat = 1'b1;
            end else begin
                m_acc = s[7:0];
            end
        end
        if (last) begin
            sb_q.push_back('{sum: m_acc, act: (m_acc >= TH), sat: m_sat});
            m_first = 1'b1;
        end else begin
            m_first = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] v, input logic last, output int waits);
        bit accepted;
        accepted = 1'b0;
        waits = 0;
        ivec = v;
        ilast = last;
        ivalid = 1'b1;
        for (int i = 0; i < 200 && !accepted; i++) begin
            @(negedge clk);
            if (iready) begin
                accepted = 1'b1;
                model_accept(v, last);
            end else begin
                waits++;
            end
            tick();
        end
        if (!accepted) check_eq("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb_q.size() != 0; i++) tick();
        check_eq("drain_empty", sb_q.size(), 32'd0);
    endtask

    // Result monitor: every transferred result is compared with the scoreboard head.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ovalid === 1'b1 && oready === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_result", 32'(ovalid), 32'd0);
            end else begin
                mon_exp = sb_q.pop_front();
                check_eq("osum", 32'(osum), 32'(mon_exp.sum));
                check_eq("oact", 32'(oact), 32'(mon_exp.act));
                check_eq("osat", 32'(osat), 32'(mon_exp.sat));
            end
        end
    end

    // Random downstream backpressure for the soak phase.
    always @(posedge clk) begin
        #1;
        if (rnd_ready_en) oready = 1'($urandom_range(0, 1));
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int w;
        int total_w;
        int len;
        rst_n = 1'b0; ivalid = 1'b0; ilast = 1'b0; ivec = 8'h00; wvec = 8'h00; oready = 1'b1;
        m_first = 1'b1; m_acc = 8'h00; m_sat = 1'b0;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check_eq("rst_ovalid", 32'(ovalid), 32'd0);
        check_eq("rst_iready", 32'(iready), 32'd0);
        check_eq("rst_osum",   32'(osum),   32'd0);
        check_eq("rst_osat",   32'(osat),   32'd0);
        check_eq("rst_oact",   32'(oact),   32'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("iready_first_cycle", 32'(iready), 32'd1);
        tick();

        // Single-beat vector and its 2-cycle latency
        send_beat(8'hFF, 1'b1, w);
        ivalid = 1'b0;
        @(negedge clk);
        check_eq("lat_cycle1_ovalid", 32'(ovalid), 32'd0);
        tick();
        @(negedge clk);
        check_eq("lat_cycle2_ovalid", 32'(ovalid), 32'd1);
        check_eq("single_osum", 32'(osum), 32'd8);
        tick();
        repeat (2) tick();

        // Back-to-back vectors: 3 beats then 1 beat, no bubble
        total_w = 0;
        send_beat(8'hFF, 1'b0, w); total_w += w;
        send_beat(8'h0F, 1'b0, w); total_w += w;
        send_beat(8'h01, 1'b1, w); total_w += w;
        send_beat(8'h03, 1'b1, w); total_w += w;
        ivalid = 1'b0;
        check_eq("no_bubble", 32'(total_w), 32'd0);
        drain();

        // Downstream stall with results pending
        oready = 1'b0;
        send_beat(8'h01, 1'b1, w);
        send_beat(8'h03, 1'b1, w);
        ivec = 8'h07; ilast = 1'b1; ivalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("stall_iready", 32'(iready), 32'd0);
            check_eq("stall_ovalid", 32'(ovalid), 32'd1);
            check_eq("stall_osum",   32'(osum),   32'(beat_count(8'h01)));
            tick();
        end
        oready = 1'b1;
        send_beat(8'h07, 1'b1, w);
        ivalid = 1'b0;
        drain();

        // Saturation over 40 full beats, then a clean vector
        for (int i = 0; i < 40; i++) send_beat(8'hFF, (i == 39), w);
        send_beat(8'h0F, 1'b1, w);
        ivalid = 1'b0;
        drain();

        // Reset in the middle of a 4-beat vector
        send_beat(8'h11, 1'b0, w);
        send_beat(8'h22, 1'b0, w);
        ivalid = 1'b0;
        tick();
        rst_n = 1'b0;
        m_first = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("midrst_ovalid", 32'(ovalid), 32'd0);
            check_eq("midrst_iready", 32'(iready), 32'd0);
            tick();
        end
        rst_n = 1'b1;
        tick();
        send_beat(8'h07, 1'b1, w);
        ivalid = 1'b0;
        drain();

`ifdef POPCOUNT_ACC_XNOR_EN
        // XNOR against weights
        wvec = 8'hF0;
        send_beat(8'hF0, 1'b1, w);
        wvec = 8'h0F;
        send_beat(8'hF0, 1'b1, w);
        ivalid = 1'b0;
        drain();
`endif

        // Random vectors under random backpressure
        rnd_ready_en = 1'b1;
        for (int v = 0; v < 15; v++) begin
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                wvec = 8'($urandom);
                send_beat(8'($urandom), (b == len - 1), w);
                if ($urandom_range(0, 3) == 0) begin
                    ivalid = 1'b0;
                    tick();
                end
            end
        end
        ivalid = 1'b0;
        rnd_ready_en = 1'b0;
        tick();
        oready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/popcount_acc.md
POPCOUNT_ACC -- requirements
Module: popcount_acc

Interface
REQ-001 SHALL have parameter VWIDTH, default 64: bits per input beat.
REQ-002 SHALL have parameter CWIDTH, default 16: accumulator and result width; CWIDTH >= clog2(VWIDTH+1).
REQ-003 SHALL have parameter THRESH, default 0: activation threshold, CWIDTH bits, unsigned.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port ivec  in  VWIDTH  input beat.
REQ-007 SHALL have port ivalid  in  1  beat valid.
REQ-008 SHALL have port ilast  in  1  final beat of the current vector.
REQ-009 SHALL have port iready  out  1  block accepts a beat this cycle.
REQ-010 SHALL have port osum  out  CWIDTH  popcount of the completed vector.
REQ-011 SHALL have port oact  out  1  binary activation: osum >= THRESH.
REQ-012 SHALL have port osat  out  1  accumulator saturated during this vector.
REQ-013 SHALL have port ovalid  out  1  result valid.
REQ-014 SHALL have port oready  in  1  downstream accepts the result.

Function
REQ-015 SHALL transfer a beat when ivalid && iready, and a result when ovalid && oready.
REQ-016 SHALL register the beat popcount in stage 1 (S1) and accumulate in stage 2 (S2); pipeline enable en = !ovalid || oready; iready = en.
REQ-017 SHALL run a 2-state FSM: FIRST (next S1 beat starts a vector, acc loads the count) and ACC (acc adds the count); FIRST->ACC on a non-last beat entering S2, ACC->FIRST on a last beat entering S2, FIRST->FIRST on a single-beat vector.
REQ-018 SHALL present the result (ovalid=1, osum, oact, osat) exactly 2 cycles after the last beat is accepted, absent stalls.
REQ-019 SHALL sustain one beat per cycle, including back-to-back vectors with no bubble.
REQ-020 SHALL hold osum, oact, osat and ovalid stable while ovalid && !oready; S1 and S2 SHALL freeze during that stall.
REQ-021 SHALL saturate acc at 2^CWIDTH-1 instead of wrapping and set osat for that vector; osat clears at the next vector's first beat.
REQ-022 SHALL drop ovalid in the cycle after a result transfer unless a new result completes in that same cycle.
REQ-023 SHALL leave ivec, ilast and ivalid ignored while iready=0.

Reset
REQ-024 SHALL, while rst_n=0 at a clock edge, clear S1, acc, osum, osat, oact and ovalid to 0, set FSM to FIRST and hold iready=0.
REQ-025 SHALL discard any partial vector on reset mid-operation; the first beat after reset starts a new vector.
REQ-026 SHALL assert iready in the first cycle with rst_n=1.

Configuration
REQ-027 SHALL, when macro POPCOUNT_ACC_XNOR_EN is defined, add port wvec (in, VWIDTH) and count popcount(~(ivec ^ wvec)); wvec is sampled with ivec.
REQ-028 SHALL, when POPCOUNT_ACC_XNOR_EN is undefined, omit wvec and count popcount(ivec).

Structure
REQ-029 SHALL place the clog2 width function, the FSM state encodings (FIRST=0, ACC=1) and the default THRESH in shared package bnn_pkg.
REQ-030 SHALL implement the beat count in sub-module popcount_tree (parameters VWIDTH, CWIDTH): a balanced adder tree, combinational, result registered by popcount_acc S1.

Verification (VWIDTH=8, CWIDTH=8, THRESH=12)
REQ-031 Single-beat vector ivec=8'hFF, ilast=1 -> ovalid after 2 cycles, osum=8, oact=0, osat=0.
REQ-032 3-beat vector 8'hFF, 8'h0F, 8'h01 (last), back-to-back with 1-beat 8'h03 -> osum=13, oact=1, then osum=2, oact=0; no bubble on iready.
REQ-033 oready=0 for 4 cycles while results pend -> iready=0, osum/ovalid held, no beat lost; all results delivered in order after release.
REQ-034 40 beats of 8'hFF with ilast on the 40th -> osum=255, osat=1; the next vector shows osat=0.
REQ-035 rst_n=0 after 2 beats of a 4-beat vector -> ovalid=0, iready=0 during reset; next 1-beat vector 8'h07 gives osum=3.
REQ-036 POPCOUNT_ACC_XNOR_EN defined, ivec=8'hF0, wvec=8'hF0, ilast=1 -> osum=8; wvec=8'h0F -> osum=0.
